// File: rtl/bemicro_cv_sysid_check.sv
// -----------------------------------------------------------------------------
// bemicro_cv_sysid_check
//
// Purpose:
//   Reads the system-ID peripheral over a minimal Avalon-MM master port and
//   compares the captured words against the values the firmware build expects.
//   The ID word is at address 0. The timestamp word is at address 1. Each read
//   tolerates up to TIMEOUT_CYCLES stalled cycles. If the slave stalls beyond
//   that, the read is abandoned and the sequence ends with the timeout flag set.
//
// Optional feature macro: SYSID_CHECK_TS_EN
//   Defined   : ID read followed by timestamp read (IDLE, RD_ID, RD_TS, FIN).
//   Undefined : timestamp read is removed (IDLE, RD_ID, FIN). In this build
//               ts_value is constant 0. ts_ok reads 1 except after a timeout
//               or while/just after reset, where it reads 0.
//
// Parameters:
//   EXPECTED_ID    - expected ID word (address 0)
//   EXPECTED_TS    - expected timestamp word (address 1)
//   TIMEOUT_CYCLES - stalled cycles tolerated per read, 1..65535
//
// Ports:
//   clock           in   single rising-edge clock
//   reset           in   asynchronous active-high reset
//   start           in   request one check sequence (ignored while busy)
//   avm_address     out  Avalon-MM word address (decoded from state)
//   avm_read        out  Avalon-MM read strobe (decoded from state)
//   avm_readdata    in   read data, valid when read=1 and waitrequest=0
//   avm_waitrequest in   slave stall
//   busy            out  sequence in progress
//   done            out  one-cycle pulse at sequence end
//   id_ok           out  captured ID matched EXPECTED_ID
//   ts_ok           out  captured timestamp matched EXPECTED_TS
//   timeout         out  last sequence aborted on stall timeout
//   id_value        out  last captured ID word
//   ts_value        out  last captured timestamp word
// -----------------------------------------------------------------------------
module bemicro_cv_sysid_check #(
  parameter logic [31:0] EXPECTED_ID    = 32'h8765_4321,
  parameter logic [31:0] EXPECTED_TS    = 32'h5292_0794,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
`ifdef SYSID_CHECK_TS_EN
    RD_TS = 2'd2,
`endif
    FIN   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
`ifdef SYSID_CHECK_TS_EN
  logic [31:0] ts_value_q, ts_value_d;
`else
  // The expected timestamp has no consumer when the timestamp read is removed.
  logic        unused_expected_ts;
  assign unused_expected_ts = ^EXPECTED_TS;
`endif

  // Next-state and result logic
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    id_value_d  = id_value_q;
`ifdef SYSID_CHECK_TS_EN
    ts_value_d  = ts_value_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RD_ID;
          stall_cnt_d = '0;
          id_ok_d     = 1'b0;
          ts_ok_d     = 1'b0;
          timeout_d   = 1'b0;
        end
      end

      RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_d = avm_readdata;
          id_ok_d    = (avm_readdata == EXPECTED_ID);
`ifdef SYSID_CHECK_TS_EN
          state_d     = RD_TS;
          stall_cnt_d = '0;
`else
          state_d     = FIN;
`endif
        end else if (stall_cnt_q == TIMEOUT_LIMIT) begin
          // Tolerated stall budget used up and the slave is still stalling.
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end

`ifdef SYSID_CHECK_TS_EN
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_d = avm_readdata;
          ts_ok_d    = (avm_readdata == EXPECTED_TS);
          state_d    = FIN;
        end else if (stall_cnt_q == TIMEOUT_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end
`endif

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifndef SYSID_CHECK_TS_EN
    // Without a timestamp read there is nothing to mismatch, so ts_ok only
    // reflects whether the sequence ran to completion.
    ts_ok_d = ~timeout_d;
`endif

    // Registered status follows the state being entered so busy/done line up
    // with the state register.
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      timeout_q   <= 1'b0;
      id_value_q  <= '0;
`ifdef SYSID_CHECK_TS_EN
      ts_value_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      id_ok_q     <= id_ok_d;
      ts_ok_q     <= ts_ok_d;
      timeout_q   <= timeout_d;
      id_value_q  <= id_value_d;
`ifdef SYSID_CHECK_TS_EN
      ts_value_q  <= ts_value_d;
`endif
    end
  end

  // Bus strobes come straight from the state register so they cannot change
  // while the slave holds waitrequest.
  always_comb begin
`ifdef SYSID_CHECK_TS_EN
    avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
    avm_address = (state_q == RD_TS);
`else
    avm_read    = (state_q == RD_ID);
    avm_address = 1'b0;
`endif
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
`ifdef SYSID_CHECK_TS_EN
  assign ts_value = ts_value_q;
`else
  assign ts_value = '0;
`endif

endmodule
